fifo_sync: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the team's dual-clock pointer FIFO, for paths where producer and consumer share one clock. Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Storage is an internal register array; no external RAM macro and no pointer synchronisers.

---
 rtl/fifo_sync_if.sv | 31 +++
 rtl/fifo_sync.sv | 85 ++++++++
 tb/tb_fifo_sync.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_if.sv
// Handshake bundle for fifo_sync: producer/consumer requests, data, and status.
// The master side drives requests; the slave (the FIFO) drives data and flags.
interface fifo_sync_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  clr;
  logic                  push;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_full;
  logic                  w_almost_full;
  logic                  pop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, push, w_data, pop,
    input  w_full, w_almost_full, r_data, r_empty, r_almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, push, w_data, pop,
    output w_full, w_almost_full, r_data, r_empty, r_almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// error flags, synchronous flush and selectable registered / FWFT read port.
module fifo_sync #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input logic       clk,
  input logic       rst_n,
  fifo_sync_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [ADDR_WIDTH:0]   occ;
  logic                  full;
  logic                  empty;
  logic                  w_en;
  logic                  r_en;
  logic                  ovf;
  logic                  udf;
  logic [DATA_WIDTH-1:0] rd;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign occ   = w_ptr - r_ptr;
  assign empty = (w_ptr == r_ptr);
  assign full  = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) &&
                 (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
  assign w_en  = bus.push & ~full;
  assign r_en  = bus.pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (bus.clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (w_en) w_ptr <= w_ptr + PTR_ONE;
      if (r_en) r_ptr <= r_ptr + PTR_ONE;
      if (bus.push && full) ovf <= 1'b1;
      if (bus.pop && empty) udf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.clr && w_en) mem[w_ptr[ADDR_WIDTH-1:0]] <= bus.w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      always_comb begin
        rd = '0;
        if (!empty) rd = mem[r_ptr[ADDR_WIDTH-1:0]];
      end
    end else begin : g_reg
      // Flush leaves the last read word visible; only reset clears it.
      always_ff @(posedge clk) begin
        if (!rst_n) rd <= '0;
        else if (!bus.clr && r_en) rd <= mem[r_ptr[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

  assign bus.r_data         = rd;
  assign bus.count          = occ;
  assign bus.w_full         = full;
  assign bus.r_empty        = empty;
  assign bus.w_almost_full  = (occ >= AF_LVL);
  assign bus.r_almost_empty = (occ <= AE_LVL);
  assign bus.overflow       = ovf;
  assign bus.underflow      = udf;
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one registered-read and one FWFT instance,
// expected read words queued at stimulus time and checked by a read monitor.
module tb_fifo_sync;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic pend0  = 1'b0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;

  fifo_sync_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus0 ();
  fifo_sync_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus1 ();

  fifo_sync #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fifo_sync #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic p, input logic [7:0] d, input logic q, input logic c);
    bus0.push = p; bus0.w_data = d; bus0.pop = q; bus0.clr = c;
    bus1.push = 0; bus1.w_data = 0; bus1.pop = 0; bus1.clr = 0;
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic p, input logic [7:0] d, input logic q, input logic c);
    bus1.push = p; bus1.w_data = d; bus1.pop = q; bus1.clr = c;
    bus0.push = 0; bus0.w_data = 0; bus0.pop = 0; bus0.clr = 0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, bus0.count, 0);
    chk({tag, "_empty"}, bus0.r_empty, 1);
    chk({tag, "_full"}, bus0.w_full, 0);
    chk({tag, "_ae"}, bus0.r_almost_empty, 1);
    chk({tag, "_af"}, bus0.w_almost_full, 0);
    chk({tag, "_ovf"}, bus0.overflow, 0);
    chk({tag, "_udf"}, bus0.underflow, 0);
    chk({tag, "_rdata"}, bus0.r_data, 0);
  endtask

  // Read monitor: registered port shows data after the accepting edge,
  // FWFT port shows the head word while pop is presented.
  always @(negedge clk) begin
    if (pend0) begin
      if (exp0.size() == 0) chk("rd0_unexpected", 1, 0);
      else chk("rd0", bus0.r_data, exp0.pop_front());
    end
    pend0 = rst_n && !bus0.clr && bus0.pop && !bus0.r_empty;
    if (rst_n && !bus1.clr && bus1.pop && !bus1.r_empty) begin
      if (exp1.size() == 0) chk("rd1_unexpected", 1, 0);
      else chk("rd1", bus1.r_data, exp1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive0(0, 0, 0, 0);
    drive0(0, 0, 0, 0);
    chk_reset("rst");
    chk("rst_rdata1", bus1.r_data, 0);
    chk("rst_empty1", bus1.r_empty, 1);
    rst_n = 1'b1;

    // Fill to full, then one rejected push
    for (int i = 1; i <= 8; i++) begin
      drive0(1, 8'(i), 0, 0);
      exp0.push_back(8'(i));
      chk("fill_count", bus0.count, i);
      chk("fill_af", bus0.w_almost_full, (i >= 6) ? 1 : 0);
      chk("fill_full", bus0.w_full, (i == 8) ? 1 : 0);
    end
    drive0(1, 8'h09, 0, 0);
    chk("ovf_count", bus0.count, 8);
    chk("ovf_flag", bus0.overflow, 1);
    chk("ovf_full", bus0.w_full, 1);

    // Drain, then one rejected pop
    for (int i = 1; i <= 8; i++) begin
      drive0(0, 0, 1, 0);
      chk("drain_count", bus0.count, 8 - i);
      chk("drain_ae", bus0.r_almost_empty, (8 - i <= 1) ? 1 : 0);
    end
    chk("drain_empty", bus0.r_empty, 1);
    drive0(0, 0, 1, 0);
    chk("udf_flag", bus0.underflow, 1);
    chk("udf_hold", bus0.r_data, 8'h08);
    chk("udf_count", bus0.count, 0);
    chk("ovf_sticky", bus0.overflow, 1);

    // Sustained push+pop at count 4 across pointer wraps
    for (int i = 0; i < 4; i++) begin
      drive0(1, 8'(8'h10 + i), 0, 0);
      exp0.push_back(8'(8'h10 + i));
    end
    for (int i = 0; i < 20; i++) begin
      drive0(1, 8'(8'h14 + i), 1, 0);
      exp0.push_back(8'(8'h14 + i));
      chk("stream_count", bus0.count, 4);
    end
    for (int i = 0; i < 4; i++) drive0(0, 0, 1, 0);
    chk("stream_end", bus0.count, 0);

    drive0(0, 0, 0, 1);
    chk("clr_ovf", bus0.overflow, 0);
    chk("clr_udf", bus0.underflow, 0);

    // Full collision: pop wins, push rejected
    for (int i = 0; i < 8; i++) begin
      drive0(1, 8'(8'h30 + i), 0, 0);
      exp0.push_back(8'(8'h30 + i));
    end
    drive0(1, 8'h38, 1, 0);
    chk("fullcol_count", bus0.count, 7);
    chk("fullcol_ovf", bus0.overflow, 1);
    chk("fullcol_full", bus0.w_full, 0);
    for (int i = 0; i < 7; i++) drive0(0, 0, 1, 0);
    drive0(0, 0, 0, 1);
    chk("clr2_udf", bus0.underflow, 0);

    // Empty collision: push wins, pop rejected
    drive0(1, 8'h55, 1, 0);
    exp0.push_back(8'h55);
    chk("emptycol_count", bus0.count, 1);
    chk("emptycol_udf", bus0.underflow, 1);
    chk("emptycol_empty", bus0.r_empty, 0);
    drive0(0, 0, 1, 0);
    chk("emptycol_drain", bus0.count, 0);

    // Flush at count 5 with overflow set; concurrent push ignored
    for (int i = 0; i < 8; i++) begin
      drive0(1, 8'(8'h60 + i), 0, 0);
      exp0.push_back(8'(8'h60 + i));
    end
    drive0(1, 8'h68, 0, 0);
    for (int i = 0; i < 3; i++) drive0(0, 0, 1, 0);
    chk("pre_flush_count", bus0.count, 5);
    chk("pre_flush_ovf", bus0.overflow, 1);
    drive0(1, 8'h99, 0, 1);
    exp0.delete();
    chk("flush_count", bus0.count, 0);
    chk("flush_ovf", bus0.overflow, 0);
    chk("flush_empty", bus0.r_empty, 1);
    chk("flush_rdata", bus0.r_data, 8'h62);
    drive0(0, 0, 0, 0);
    chk("flush_nopush", bus0.count, 0);

    // FWFT instance
    drive1(1, 8'hA5, 0, 0);
    exp1.push_back(8'hA5);
    chk("fwft_show", bus1.r_data, 8'hA5);
    chk("fwft_count", bus1.count, 1);
    drive1(0, 0, 1, 0);
    chk("fwft_zero", bus1.r_data, 0);
    chk("fwft_empty", bus1.r_empty, 1);
    drive1(1, 8'hB1, 0, 0);
    exp1.push_back(8'hB1);
    drive1(1, 8'hB2, 0, 0);
    exp1.push_back(8'hB2);
    drive1(0, 0, 1, 0);
    chk("fwft_next", bus1.r_data, 8'hB2);
    drive1(0, 0, 1, 0);
    chk("fwft_drained", bus1.r_empty, 1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive0(1, 8'(8'h70 + i), 0, 0);
      exp0.push_back(8'(8'h70 + i));
    end
    drive0(0, 0, 1, 0);
    rst_n = 1'b0;
    drive0(1, 8'h80, 1, 0);
    exp0.delete();
    chk_reset("midrst");
    rst_n = 1'b1;
    drive0(1, 8'hAB, 0, 0);
    exp0.push_back(8'hAB);
    chk("post_rst_count", bus0.count, 1);
    drive0(0, 0, 1, 0);
    drive0(0, 0, 0, 0);
    chk("sb0_drained", exp0.size(), 0);
    chk("sb1_drained", exp1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
